// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath constants and encodings
// Widths, write-back select encodings and the hard-wired zero register index.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  // MEM/WB mux3 encoding
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam int R0 = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back / register-file port bundle
// MEM/WB inputs, the two ID read ports and the trace outputs.
interface wb_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);

  logic              wb_sel;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] last_wr_addr;
  logic [DATA_W-1:0] last_wr_data;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output wb_sel, wb_en, wb_addr, alu_data, mem_data, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, last_wr_addr, last_wr_data, wr_count
  );

  modport slave (
    input  wb_sel, wb_en, wb_addr, alu_data, mem_data, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, last_wr_addr, last_wr_data, wr_count
  );

endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read 1-write register storage
// Raw storage only: no bypass and no zero-register handling.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Depth is a full power of two, so every index is in range.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and architectural register file
// Write-back mux, same-cycle read bypass, R0 handling, write trace and counter.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave bus
);

  localparam logic [ADDR_W-1:0] R0_IDX = ADDR_W'(R0);

  logic [DATA_W-1:0] wb_data_c;
  logic [DATA_W-1:0] raw_a;
  logic [DATA_W-1:0] raw_b;
  logic [DATA_W-1:0] rs_c;
  logic [DATA_W-1:0] rt_c;
  logic              wr_to_r0;
  logic              commit;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic [CNT_W-1:0]  count_q;

  assign wb_data_c = (bus.wb_sel == WB_SEL_MEM) ? bus.mem_data : bus.alu_data;

  // A write to R0 is dropped entirely: storage, trace and counter all ignore it.
  assign wr_to_r0 = ZERO_REG && (bus.wb_addr == R0_IDX);
  assign commit   = bus.wb_en && !wr_to_r0;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit),
    .waddr   (bus.wb_addr),
    .wdata   (wb_data_c),
    .raddr_a (bus.rs_addr),
    .rdata_a (raw_a),
    .raddr_b (bus.rt_addr),
    .rdata_b (raw_b)
  );

  always_comb begin
    rs_c = raw_a;
    if (commit && (bus.rs_addr == bus.wb_addr)) begin
      rs_c = wb_data_c;
    end
    if (ZERO_REG && (bus.rs_addr == R0_IDX)) begin
      rs_c = '0;
    end
  end

  always_comb begin
    rt_c = raw_b;
    if (commit && (bus.rt_addr == bus.wb_addr)) begin
      rt_c = wb_data_c;
    end
    if (ZERO_REG && (bus.rt_addr == R0_IDX)) begin
      rt_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= '0;
      last_data_q <= '0;
      count_q     <= '0;
    end else if (commit) begin
      last_addr_q <= bus.wb_addr;
      last_data_q <= wb_data_c;
      if (count_q != '1) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.wb_data      = wb_data_c;
  assign bus.rs_data      = rs_c;
  assign bus.rt_data      = rt_c;
  assign bus.last_wr_addr = last_addr_q;
  assign bus.last_wr_data = last_data_q;
  assign bus.wr_count     = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile
// Directed vectors push expectations; a monitor pops and compares them.
module tb_wb_regfile;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) bus ();
  wb_regfile_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(2))  bus_s ();

  wb_regfile #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1'b1), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wb_regfile #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1'b1), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  assign bus_s.wb_sel   = bus.wb_sel;
  assign bus_s.wb_en    = bus.wb_en;
  assign bus_s.wb_addr  = bus.wb_addr;
  assign bus_s.alu_data = bus.alu_data;
  assign bus_s.mem_data = bus.mem_data;
  assign bus_s.rs_addr  = bus.rs_addr;
  assign bus_s.rt_addr  = bus.rt_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_RS, S_RT, S_WB, S_LADDR, S_LDATA, S_CNT, S_SCNT, S_SLADDR, S_SLDATA
  } sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [15:0] actual(sig_e s);
    case (s)
      S_RS:     return {8'h0, bus.rs_data};
      S_RT:     return {8'h0, bus.rt_data};
      S_WB:     return {8'h0, bus.wb_data};
      S_LADDR:  return {12'h0, bus.last_wr_addr};
      S_LDATA:  return {8'h0, bus.last_wr_data};
      S_CNT:    return bus.wr_count;
      S_SCNT:   return {14'h0, bus_s.wr_count};
      S_SLADDR: return {12'h0, bus_s.last_wr_addr};
      S_SLDATA: return {8'h0, bus_s.last_wr_data};
      default:  return 16'hxxxx;
    endcase
  endfunction

  // Monitor: every pushed expectation is compared against the live outputs.
  initial begin
    exp_t e;
    logic [15:0] a;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      a = actual(e.sig);
      n_vec++;
      if (a !== e.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, a, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input string name, input sig_e s, input logic [15:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic en, input logic sel, input logic [3:0] wa,
                       input logic [7:0] alu, input logic [7:0] mem,
                       input logic [3:0] rs, input logic [3:0] rt);
    bus.wb_en    = en;
    bus.wb_sel   = sel;
    bus.wb_addr  = wa;
    bus.alu_data = alu;
    bus.mem_data = mem;
    bus.rs_addr  = rs;
    bus.rt_addr  = rt;
  endtask

  // Let expectations settle and be consumed before the next stimulus change.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd5, 4'd15);
    @(negedge clk);
    #1;
    expect_val("reset_rs", S_RS, 16'h0);
    expect_val("reset_rt", S_RT, 16'h0);
    expect_val("reset_cnt", S_CNT, 16'h0);
    expect_val("reset_laddr", S_LADDR, 16'h0);
    expect_val("reset_ldata", S_LDATA, 16'h0);
    expect_val("reset_scnt", S_SCNT, 16'h0);
    settle();

    // ALU write to R3 with same-cycle bypass
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'd3, 8'h5A, 8'hFF, 4'd3, 4'd4);
    #1;
    expect_val("alu_bypass_rs", S_RS, 16'h5A);
    expect_val("alu_wbdata", S_WB, 16'h5A);
    expect_val("alu_other_rt", S_RT, 16'h0);
    expect_val("alu_cnt_before", S_CNT, 16'h0);
    settle();

    @(negedge clk);
    drive(1'b0, 1'b0, 4'd3, 8'h11, 8'hFF, 4'd3, 4'd4);
    #1;
    expect_val("alu_stored_rs", S_RS, 16'h5A);
    expect_val("alu_cnt", S_CNT, 16'h1);
    expect_val("alu_ldata", S_LDATA, 16'h5A);
    expect_val("alu_laddr", S_LADDR, 16'h3);
    expect_val("idle_wbdata", S_WB, 16'h11);
    settle();

    // Load write with both read ports bypassing
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd7, 8'h12, 8'hC3, 4'd7, 4'd7);
    #1;
    expect_val("load_bypass_rs", S_RS, 16'hC3);
    expect_val("load_bypass_rt", S_RT, 16'hC3);
    expect_val("load_wbdata", S_WB, 16'hC3);
    settle();

    @(negedge clk);
    drive(1'b0, 1'b1, 4'd7, 8'h12, 8'hC3, 4'd7, 4'd3);
    #1;
    expect_val("load_stored_rs", S_RS, 16'hC3);
    expect_val("load_r3_rt", S_RT, 16'h5A);
    expect_val("load_cnt", S_CNT, 16'h2);
    expect_val("load_laddr", S_LADDR, 16'h7);
    settle();

    // R0 writes are discarded and R0 always reads zero
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd0, 8'h77, 8'h00, 4'd0, 4'd0);
    #1;
    expect_val("r0_during_rs", S_RS, 16'h0);
    expect_val("r0_during_rt", S_RT, 16'h0);
    expect_val("r0_wbdata", S_WB, 16'h77);
    settle();

    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 8'h77, 8'h00, 4'd0, 4'd7);
    #1;
    expect_val("r0_after_rs", S_RS, 16'h0);
    expect_val("r0_cnt", S_CNT, 16'h2);
    expect_val("r0_laddr", S_LADDR, 16'h7);
    expect_val("r0_ldata", S_LDATA, 16'hC3);
    settle();

    // Bypass only on the matching port
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd5, 8'h99, 8'h00, 4'd5, 4'd6);
    #1;
    expect_val("r5_bypass_rs", S_RS, 16'h99);
    expect_val("r5_nobypass_rt", S_RT, 16'h0);
    settle();

    @(negedge clk);
    drive(1'b0, 1'b0, 4'd5, 8'h00, 8'h00, 4'd3, 4'd5);
    #1;
    expect_val("pre_reset_rs", S_RS, 16'h5A);
    expect_val("r5_stored_rt", S_RT, 16'h99);
    expect_val("r5_cnt", S_CNT, 16'h3);
    settle();

    // Asynchronous reset between edges; write held across the reset edge
    #1;
    rst_n = 1'b0;
    #1;
    expect_val("async_rs", S_RS, 16'h0);
    expect_val("async_rt", S_RT, 16'h0);
    expect_val("async_cnt", S_CNT, 16'h0);
    settle();
    drive(1'b1, 1'b0, 4'd9, 8'h42, 8'h00, 4'd3, 4'd9);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 4'd9, 8'h42, 8'h00, 4'd3, 4'd9);
    #1;
    expect_val("rst_edge_rt", S_RT, 16'h0);
    expect_val("rst_edge_cnt", S_CNT, 16'h0);
    expect_val("rst_edge_laddr", S_LADDR, 16'h0);
    settle();

    // Five consecutive commits; the CNT_W=2 instance saturates at 3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      case (i)
        0: drive(1'b1, 1'b0, 4'd1, 8'h10, 8'h00, 4'd0, 4'd0);
        1: drive(1'b1, 1'b1, 4'd2, 8'h00, 8'h11, 4'd0, 4'd0);
        2: drive(1'b1, 1'b0, 4'd4, 8'h12, 8'h00, 4'd0, 4'd0);
        3: drive(1'b1, 1'b0, 4'd6, 8'h13, 8'h00, 4'd0, 4'd0);
        default: drive(1'b1, 1'b1, 4'd8, 8'h00, 8'h14, 4'd0, 4'd0);
      endcase
      if (i == 4) begin
        #1;
        expect_val("sat_cnt_mid", S_SCNT, 16'h3);
        settle();
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd4, 4'd8);
    #1;
    expect_val("sat_cnt", S_SCNT, 16'h3);
    expect_val("sat_laddr", S_SLADDR, 16'h8);
    expect_val("sat_ldata", S_SLDATA, 16'h14);
    expect_val("main_cnt5", S_CNT, 16'h5);
    expect_val("burst_r4", S_RS, 16'h12);
    expect_val("burst_r8", S_RT, 16'h14);
    settle();

    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0);
    #1;
    expect_val("sat_hold", S_SCNT, 16'h3);
    settle();

    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file of the 8-bit pipelined CPU.
- Sits directly downstream of the MEM/WB pipeline register and consumes its outputs: write register index, ALU result, memory data, write-back select, register-write enable.
- Selects the write-back value, commits it to the register file, and serves the two ID-stage read ports.
- Read ports include same-cycle write-through bypass, so ID sees the value being retired this cycle.

Parameters:
- DATA_W, 8, register and datapath width.
- ADDR_W, 4, register index width; register file depth is 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_sel  in  1  write-back select from MEM/WB (mux3): 1 = mem_data, 0 = alu_data.
- wb_en  in  1  register-write enable from MEM/WB (regwrt).
- wb_addr  in  ADDR_W  destination register index.
- alu_data  in  DATA_W  ALU result from MEM/WB.
- mem_data  in  DATA_W  memory load data from MEM/WB.
- rs_addr  in  ADDR_W  read port A index (ID stage).
- rt_addr  in  ADDR_W  read port B index (ID stage).
- rs_data  out  DATA_W  read port A data, combinational.
- rt_data  out  DATA_W  read port B data, combinational.
- wb_data  out  DATA_W  selected write-back value, combinational; also fed to EX forwarding.
- last_wr_addr  out  ADDR_W  index of the most recent committed write, registered.
- last_wr_data  out  DATA_W  data of the most recent committed write, registered.
- wr_count  out  CNT_W  number of committed writes, saturating, registered.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, last_wr_addr = 0, last_wr_data = 0, wr_count = 0. Combinational outputs then reflect the zeroed state. Reset asserted mid-operation aborts any pending write on that edge.
- wb_data = wb_sel ? mem_data : alu_data. Valid regardless of wb_en.
- Commit: on rising clk with rst_n high and wb_en = 1:
  - regs[wb_addr] <= wb_data.
  - last_wr_addr <= wb_addr, last_wr_data <= wb_data.
  - wr_count increments, saturating at 2**CNT_W - 1.
- Discarded write: with ZERO_REG = 1 and wb_addr = 0, the write is discarded: no register, last_wr, or counter update.
- wb_en = 0: no state change.
- Read: rs_data = regs[rs_addr], with bypass. If wb_en = 1 and rs_addr = wb_addr (and the write is not a discarded write to R0), rs_data = wb_data. rt_data is identical using rt_addr.
- R0: with ZERO_REG = 1, rs_addr = 0 or rt_addr = 0 yields 0 always, including during a write to R0.
- Both read ports may address the same register as each other and as the write port simultaneously; both bypass.
- Latency: written value is visible on the read ports combinationally in the same cycle (bypass) and from storage from the next cycle on.
- Timing: MEM/WB latches on negedge and this block commits on posedge, so the inputs are stable for a half cycle before commit. This phase relationship is required.
- No X propagation: all storage is reset. Read indices are always in range because depth = 2**ADDR_W.

Decomposition:
- Shared cpu_pkg: DATA_W and ADDR_W constants, WB_SEL_ALU = 0 and WB_SEL_MEM = 1 encodings, and register index constant R0 = 0.
- One natural sub-module, regfile_2r1w: storage array, asynchronous reset, write port, two raw read ports.
- wb_regfile adds the write-back mux, bypass, R0 handling, trace registers, and counter around it.

Test Plan:
- Reset: rst_n low, then drive rs_addr = 5 and rt_addr = 15 -> rs_data = 0, rt_data = 0, wr_count = 0, last_wr_addr = 0.
- ALU write: wb_en = 1, wb_sel = 0, wb_addr = 3, alu_data = 0x5A, mem_data = 0xFF, rs_addr = 3 -> rs_data = 0x5A in the same cycle (bypass). After the edge, with wb_en = 0: rs_data = 0x5A, wr_count = 1, last_wr_data = 0x5A.
- Load write and dual bypass: wb_sel = 1, wb_addr = 7, mem_data = 0xC3, rs_addr = rt_addr = 7, wb_en = 1 -> both ports = 0xC3, wb_data = 0xC3. Next cycle storage holds 0xC3.
- R0 protection: wb_en = 1, wb_addr = 0, alu_data = 0x77, rs_addr = 0 -> rs_data = 0 during and after the edge, and wr_count unchanged.
- Asynchronous reset mid-run: regs[3] = 0x5A, then pulse rst_n low between edges -> rs_data(3) = 0 immediately, before the next clk edge. A write asserted on the reset edge is not committed.
- Counter saturation (CNT_W overridden to 2): 5 consecutive valid writes -> wr_count = 3 holds; last_wr_addr and last_wr_data track the 5th write.
